// File: rtl/sb_scan_pkg.sv
// sb_scan_pkg: shared types and constants for the DSP port scanner.
//   scan_state_e   probe FSM state encoding
//   DSP_*_OFS      register offsets within one candidate DSP base
//   DSP_RESET_*    values written to the DSP reset register
//   DSP_READY_BYTE byte a present DSP returns after reset
//   clog2()        ceiling log2, used for counter widths
package sb_scan_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST_HI = 3'd1,
    HOLD   = 3'd2,
    RST_LO = 3'd3,
    POLL   = 3'd4,
    READ   = 3'd5,
    NEXT   = 3'd6,
    DONE   = 3'd7
  } scan_state_e;

  localparam logic [3:0] DSP_RESET_OFS  = 4'h6;
  localparam logic [3:0] DSP_READ_OFS   = 4'hA;
  localparam logic [3:0] DSP_STAT_OFS   = 4'hE;
  localparam logic [7:0] DSP_READY_BYTE = 8'hAA;
  localparam logic [7:0] DSP_RESET_ON   = 8'h01;
  localparam logic [7:0] DSP_RESET_OFF  = 8'h00;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sb_bus_xact.sv
// sb_bus_xact: one-deep request/ack register stage toward the bus master.
//   go/wr/addr/wdata  launch a transaction (taken only while idle)
//   ack/rdata         completion strobe and read data (same cycle as bus_ack)
//   idle              no transaction outstanding
//   bus_*             registered request side and raw ack/rdata of the bus
// The request fields are held until bus_ack is seen; bus_req drops on the
// following edge, so back-to-back launches always leave one idle cycle.
module sb_bus_xact
  (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        idle,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= 16'h0000;
      bus_wdata <= 8'h00;
    end else if (bus_req) begin
      if (bus_ack) bus_req <= 1'b0;
    end else if (go) begin
      bus_req   <= 1'b1;
      bus_wr    <= wr;
      bus_addr  <= addr;
      bus_wdata <= wdata;
    end
  end

  // an ack with no request outstanding is dropped here
  assign ack   = bus_req & bus_ack;
  assign rdata = bus_rdata;
  assign idle  = ~bus_req;

endmodule

// File: rtl/sb_port_scanner.sv
// sb_port_scanner: walks NUM_PORTS candidate DSP bases, runs the reset
// handshake at each and records which ones answer with the ready byte.
//   clk, reset             system clock, synchronous active-high reset
//   start, stop_on_first   launch a scan (IDLE/DONE only); stop at first hit
//   busy, done             scan in progress / results valid
//   found_map, found_any   per-base responder bitmap and its OR
//   first_addr             base of the lowest-index responder (0 if none)
//   bus_*                  request/ack bus-master interface
//
// state  | meaning
// IDLE   | waiting for start, results cleared by reset
// RST_HI | write DSP_RESET_ON to base+6
// HOLD   | hold reset high for HOLD_CYCLES
// RST_LO | write DSP_RESET_OFF to base+6, arm timeout
// POLL   | read base+E until bit7 set or timeout
// READ   | read base+A, ready byte marks the port found
// NEXT   | record first hit, decide finish or advance index
// DONE   | scan finished, results held
module sb_port_scanner
  import sb_scan_pkg::*;
#(
  parameter logic [15:0] BASE_START     = 16'h0200,
  parameter logic [15:0] STRIDE         = 16'h0010,
  parameter int          NUM_PORTS      = 16,
  parameter int          HOLD_CYCLES    = 64,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop_on_first,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_PORTS-1:0] found_map,
  output logic                 found_any,
  output logic [15:0]          first_addr,
  output logic                 bus_req,
  output logic                 bus_wr,
  output logic [15:0]          bus_addr,
  output logic [7:0]           bus_wdata,
  input  logic [7:0]           bus_rdata,
  input  logic                 bus_ack
);

  localparam int IDX_W  = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? clog2(HOLD_CYCLES) : 1;
  localparam int TMO_W  = clog2(TIMEOUT_CYCLES + 1);

  scan_state_e       state, state_nxt;
  logic [IDX_W-1:0]  index;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              stop_lat;
  logic              hit_seen;

  logic              x_go, x_wr, x_ack, x_idle;
  logic [15:0]       x_addr;
  logic [7:0]        x_wdata, x_rdata;

  logic [15:0]       base;
  logic              hit, last, tmo_exp, hold_done, ready_ack;

  // modulo-2^16 wrap of the base address is intentional
  assign base      = BASE_START + 16'(index) * STRIDE;
  assign hit       = found_map[index];
  assign last      = (index == IDX_W'(NUM_PORTS - 1));
  assign tmo_exp   = (tmo_cnt == '0);
  assign hold_done = (hold_cnt == '0);
  assign ready_ack = x_ack && (x_rdata == DSP_READY_BYTE);
  assign found_any = |found_map;

  sb_bus_xact u_xact (
    .clk       (clk),
    .reset     (reset),
    .go        (x_go),
    .wr        (x_wr),
    .addr      (x_addr),
    .wdata     (x_wdata),
    .ack       (x_ack),
    .rdata     (x_rdata),
    .idle      (x_idle),
    .bus_req   (bus_req),
    .bus_wr    (bus_wr),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // In POLL/READ an outstanding ack is always evaluated first; the timeout
  // only ends the port once the bus is idle again.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RST_HI;
      RST_HI:     if (x_ack) state_nxt = HOLD;
      HOLD:       if (hold_done) state_nxt = RST_LO;
      RST_LO:     if (x_ack) state_nxt = POLL;
      POLL: begin
        if (x_ack) begin
          if (x_rdata[7]) state_nxt = READ;
        end else if (x_idle && tmo_exp) begin
          state_nxt = NEXT;
        end
      end
      READ: begin
        if (x_ack) state_nxt = ready_ack ? NEXT : POLL;
        else if (x_idle && tmo_exp) state_nxt = NEXT;
      end
      NEXT:       state_nxt = ((stop_lat && hit) || last) ? DONE : RST_HI;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_go    = 1'b0;
    x_wr    = 1'b0;
    x_addr  = base + {12'h000, DSP_RESET_OFS};
    x_wdata = 8'h00;
    busy    = (state != IDLE) && (state != DONE);
    done    = (state == DONE);
    case (state)
      RST_HI: begin
        x_go    = x_idle;
        x_wr    = 1'b1;
        x_wdata = DSP_RESET_ON;
      end
      RST_LO: begin
        x_go    = x_idle;
        x_wr    = 1'b1;
        x_wdata = DSP_RESET_OFF;
      end
      POLL: begin
        x_go   = x_idle && !tmo_exp;
        x_addr = base + {12'h000, DSP_STAT_OFS};
      end
      READ: begin
        x_go   = x_idle && !tmo_exp;
        x_addr = base + {12'h000, DSP_READ_OFS};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index      <= '0;
      hold_cnt   <= '0;
      tmo_cnt    <= '0;
      stop_lat   <= 1'b0;
      hit_seen   <= 1'b0;
      found_map  <= '0;
      first_addr <= 16'h0000;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            index      <= '0;
            stop_lat   <= stop_on_first;
            hit_seen   <= 1'b0;
            found_map  <= '0;
            first_addr <= 16'h0000;
          end
        end
        RST_HI: if (x_ack) hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
        HOLD:   if (!hold_done) hold_cnt <= hold_cnt - HOLD_W'(1);
        RST_LO: if (x_ack) tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
        POLL:   if (!tmo_exp) tmo_cnt <= tmo_cnt - TMO_W'(1);
        READ: begin
          if (!tmo_exp) tmo_cnt <= tmo_cnt - TMO_W'(1);
          if (ready_ack) found_map[index] <= 1'b1;
        end
        NEXT: begin
          if (hit && !hit_seen) begin
            first_addr <= base;
            hit_seen   <= 1'b1;
          end
          if (state_nxt == RST_HI) index <= index + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_port_scanner.sv
module tb_sb_port_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start_a, sof_a, busy_a, done_a, fany_a;
  logic [15:0] fmap_a, first_a, addr_a;
  logic        req_a, wr_a;
  logic [7:0]  wdata_a;
  logic [7:0]  rdata_a = 8'h00;
  logic        ack_a   = 1'b0;

  logic        start_b, sof_b, busy_b, done_b, fany_b;
  logic [0:0]  fmap_b;
  logic [15:0] first_b, addr_b;
  logic        req_b, wr_b;
  logic [7:0]  wdata_b;
  logic [7:0]  rdata_b = 8'h00;
  logic        ack_b   = 1'b0;

  sb_port_scanner #(
    .BASE_START(16'h0200), .STRIDE(16'h0010), .NUM_PORTS(16),
    .HOLD_CYCLES(8), .TIMEOUT_CYCLES(32)
  ) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stop_on_first(sof_a),
    .busy(busy_a), .done(done_a), .found_map(fmap_a), .found_any(fany_a),
    .first_addr(first_a), .bus_req(req_a), .bus_wr(wr_a), .bus_addr(addr_a),
    .bus_wdata(wdata_a), .bus_rdata(rdata_a), .bus_ack(ack_a)
  );

  sb_port_scanner #(
    .BASE_START(16'hFFF0), .STRIDE(16'h0010), .NUM_PORTS(1),
    .HOLD_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stop_on_first(sof_b),
    .busy(busy_b), .done(done_b), .found_map(fmap_b), .found_any(fany_b),
    .first_addr(first_b), .bus_req(req_b), .bus_wr(wr_b), .bus_addr(addr_b),
    .bus_wdata(wdata_b), .bus_rdata(rdata_b), .bus_ack(ack_b)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus model for DUT A ----------------
  int          lat_a     = 1;
  logic [15:0] resp_mask = 16'h0000;
  int          bad_cfg [16];
  int          clr_seq   = 0;

  int          clr_seen  = 0;
  int          cyc       = 0;
  int          wcnt_a    = 0;
  logic        req_prev_a = 1'b0;
  int          n_rsthi_a = 0;
  int          n_reads [16];
  logic [15:0] max_addr_a = 16'h0000;
  logic [15:0] first_req_a = 16'h0000;
  logic        first_seen_a = 1'b0;
  int          t_hi = 0, t_lo = 0;
  logic        arm_hold = 1'b0, arm_poll = 1'b0;
  int          hold_min = 999999, hold_max = 0;
  int          poll_min = 999999, poll_max = 0, n_poll = 0;

  always @(negedge clk) begin : bus_model_a
    int          k, gap;
    logic [15:0] off;
    cyc++;
    if (clr_seq != clr_seen) begin
      clr_seen     = clr_seq;
      n_rsthi_a    = 0;
      for (int i = 0; i < 16; i++) n_reads[i] = 0;
      max_addr_a   = 16'h0000;
      first_seen_a = 1'b0;
      first_req_a  = 16'h0000;
      arm_hold     = 1'b0;
      arm_poll     = 1'b0;
      hold_min     = 999999;
      hold_max     = 0;
      poll_min     = 999999;
      poll_max     = 0;
      n_poll       = 0;
    end
    if (req_a && !req_prev_a) begin
      if (!first_seen_a) begin
        first_seen_a = 1'b1;
        first_req_a  = addr_a;
      end
      if (arm_hold && wr_a && addr_a[3:0] == 4'h6 && wdata_a == 8'h00) begin
        gap = cyc - t_hi;
        if (gap < hold_min) hold_min = gap;
        if (gap > hold_max) hold_max = gap;
        arm_hold = 1'b0;
      end
      if (arm_poll && wr_a && addr_a[3:0] == 4'h6 && wdata_a == 8'h01) begin
        gap = cyc - t_lo;
        if (gap < poll_min) poll_min = gap;
        if (gap > poll_max) poll_max = gap;
        n_poll++;
        arm_poll = 1'b0;
      end
    end
    req_prev_a = req_a;
    if (ack_a) begin
      ack_a  = 1'b0;
      wcnt_a = 0;
    end else if (req_a) begin
      wcnt_a++;
      if (wcnt_a >= lat_a) begin
        ack_a   = 1'b1;
        off     = addr_a - 16'h0200;
        k       = int'(off[15:4]);
        rdata_a = 8'hFF;
        if (addr_a > max_addr_a) max_addr_a = addr_a;
        if (wr_a) begin
          if (addr_a[3:0] == 4'h6 && wdata_a == 8'h01) begin
            n_rsthi_a++;
            t_hi     = cyc;
            arm_hold = 1'b1;
          end else if (addr_a[3:0] == 4'h6 && wdata_a == 8'h00) begin
            t_lo     = cyc;
            arm_poll = 1'b1;
          end
        end else if (k < 16) begin
          if (addr_a[3:0] == 4'hE) begin
            rdata_a = resp_mask[k] ? 8'h80 : 8'h00;
          end else if (addr_a[3:0] == 4'hA) begin
            n_reads[k]++;
            if (resp_mask[k]) rdata_a = (n_reads[k] > bad_cfg[k]) ? 8'hAA : 8'h55;
          end
        end
      end
    end else begin
      wcnt_a = 0;
    end
  end

  // ---------------- bus model for DUT B (always present, 1-cycle ack) ----------------
  int          n_rsthi_b  = 0;
  logic [15:0] stat_addr_b = 16'h0000;

  always @(negedge clk) begin : bus_model_b
    if (ack_b) begin
      ack_b = 1'b0;
    end else if (req_b) begin
      ack_b = 1'b1;
      if (wr_b && addr_b[3:0] == 4'h6 && wdata_b == 8'h01) n_rsthi_b++;
      if (!wr_b && addr_b[3:0] == 4'hE) stat_addr_b = addr_b;
      rdata_b = (addr_b[3:0] == 4'hE) ? 8'h80 : 8'hAA;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] fmap;
    logic [15:0] first;
    int          n_rsthi;
    int          n_reads1;
    logic [15:0] max_addr;
  } exp_t;

  exp_t sb_q[$];

  function automatic exp_t predict(input logic [15:0] mask, input logic stop, input int bad1);
    exp_t e;
    int   lo, last;
    lo = -1;
    for (int i = 15; i >= 0; i--) if (mask[i]) lo = i;
    e.fmap     = (stop && lo >= 0) ? (16'h0001 << lo) : mask;
    e.first    = (lo >= 0) ? (16'h0200 + 16'(lo) * 16'h0010) : 16'h0000;
    last       = (stop && lo >= 0) ? lo : 15;
    e.n_rsthi  = last + 1;
    e.max_addr = 16'h0200 + 16'(last) * 16'h0010 + 16'h000E;
    e.n_reads1 = (last >= 1 && mask[1]) ? bad1 + 1 : 0;
    return e;
  endfunction

  task automatic start_a_scan(input logic [15:0] mask, input logic stop, input int lat, input bit push);
    resp_mask = mask;
    lat_a     = lat;
    clr_seq++;
    @(negedge clk);
    if (push) sb_q.push_back(predict(mask, stop, bad_cfg[1]));
    sof_a   = stop;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    sof_a   = 1'b0;
    chk("busy_after_start", busy_a, 1);
    chk("done_cleared", done_a, 0);
  endtask

  task automatic wait_done_a(input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (!done_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_a", done_a, 1);
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("found_map", fmap_a, e.fmap);
      chk("first_addr", first_a, e.first);
      chk("found_any", fany_a, |e.fmap);
      chk("busy_at_done", busy_a, 0);
      chk("rst_hi_writes", n_rsthi_a, e.n_rsthi);
      chk("reads_0x21A", n_reads[1], e.n_reads1);
      chk("max_bus_addr", max_addr_a, e.max_addr);
    end
  endtask

  initial begin
    int  n;
    bit  hit5;
    reset   = 1'b1;
    start_a = 1'b0;
    sof_a   = 1'b0;
    start_b = 1'b0;
    sof_b   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_found_map", fmap_a, 0);
    chk("rst_first_addr", first_a, 0);
    chk("rst_bus_req", req_a, 0);
    chk("rst_bus_addr", addr_a, 0);
    chk("rst_found_any", fany_a, 0);
    reset = 1'b0;
    @(negedge clk);

    // single responder at 0x220, scan all
    start_a_scan(16'h0004, 1'b0, 1, 1'b1);
    wait_done_a(4000);
    chk("hold_gap_min", hold_min, 10);
    chk("hold_gap_max", hold_max, 10);
    repeat (5) @(negedge clk);
    chk("done_held", done_a, 1);

    // responders at 0x220/0x240, stop on first; extra start while busy ignored
    start_a_scan(16'h0014, 1'b1, 1, 1'b1);
    repeat (20) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(4000);

    // nobody home, slow bus
    start_a_scan(16'h0000, 1'b0, 3, 1'b1);
    wait_done_a(6000);
    chk("poll_phases", n_poll, 15);
    chk("poll_phase_min_ok", (poll_min >= 32), 1);
    chk("poll_phase_max_ok", (poll_max <= 44), 1);

    // 0x210 answers 0x55 twice before 0xAA
    bad_cfg[1] = 2;
    start_a_scan(16'h0002, 1'b1, 1, 1'b1);
    wait_done_a(3000);

    // reset while a request is outstanding at port 5
    start_a_scan(16'h0000, 1'b0, 3, 1'b0);
    n    = 0;
    hit5 = 1'b0;
    while (!hit5 && n < 3000) begin
      if (req_a && addr_a[15:4] == 12'h025) hit5 = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("reached_port5", hit5, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_bus_req", req_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_found_map", fmap_a, 0);
    chk("midrst_done", done_a, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_a_scan(16'h0001, 1'b1, 1, 1'b1);
    wait_done_a(3000);
    chk("restart_first_req", first_req_a, 16'h0206);

    // one port at the top of the address space
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_busy", busy_b, 1);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("b_done", done_b, 1);
    chk("b_busy_end", busy_b, 0);
    chk("b_found_map", fmap_b, 1);
    chk("b_found_any", fany_b, 1);
    chk("b_first_addr", first_b, 16'hFFF0);
    chk("b_stat_addr", stat_addr_b, 16'hFFFE);
    chk("b_rst_hi_writes", n_rsthi_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
